// File: rtl/if_axi_read_bridge_pkg.sv
// Shared definitions for the instruction-fetch to AXI4 read bridge.
// Holds transfer-size codes, AXI burst/response codes and the bridge FSM state type.
package if_axi_read_bridge_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR,
    StResp
  } state_e;

endpackage

// File: rtl/if_axi_read_bridge_if.sv
// Bundle of the fetch-side valid/ready request channel and the AXI4 AR/R channels.
// Modports:
//   slave  - the bridge: responds to fetch requests, masters the AXI read channels.
//   master - the environment: IF stage driving requests plus the AXI slave answering them.
// Parameter ID_W sets the width of axi_ar_id / axi_r_id.
interface if_axi_read_bridge_if #(
  parameter int unsigned ID_W = 4
) ();

  // Fetch side
  logic            if_valid;
  logic [63:0]     if_addr;
  logic [1:0]      if_size;
  logic            if_ready;
  logic [63:0]     if_data_read;
  logic [1:0]      if_resp;

  // AXI read address channel
  logic            axi_ar_valid;
  logic            axi_ar_ready;
  logic [63:0]     axi_ar_addr;
  logic [ID_W-1:0] axi_ar_id;
  logic [7:0]      axi_ar_len;
  logic [2:0]      axi_ar_size;
  logic [1:0]      axi_ar_burst;

  // AXI read data channel
  logic            axi_r_valid;
  logic            axi_r_ready;
  logic [63:0]     axi_r_data;
  logic [1:0]      axi_r_resp;
  logic [ID_W-1:0] axi_r_id;
  logic            axi_r_last;

  modport slave (
    input  if_valid, if_addr, if_size,
    output if_ready, if_data_read, if_resp,
    output axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
    input  axi_ar_ready,
    input  axi_r_valid, axi_r_data, axi_r_resp, axi_r_id, axi_r_last,
    output axi_r_ready
  );

  modport master (
    output if_valid, if_addr, if_size,
    input  if_ready, if_data_read, if_resp,
    input  axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
    output axi_ar_ready,
    output axi_r_valid, axi_r_data, axi_r_resp, axi_r_id, axi_r_last,
    input  axi_r_ready
  );

endinterface

// File: rtl/if_axi_read_bridge_align.sv
// Lane alignment for fetched read data (used only when IF_RDATA_ALIGN_EN is defined).
// Shifts the 64-bit beat right so the addressed byte sits at bit 0, then zeroes bytes
// above the transfer size.
// Ports:
//   rdata_i  [63:0] raw AXI beat
//   offset_i [2:0]  byte offset of the fetch address within the beat
//   size_i   [1:0]  transfer size (B/H/W/D)
//   data_o   [63:0] aligned, size-masked data
module if_axi_read_bridge_align
  import if_axi_read_bridge_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = shifted;
    unique case (size_i)
      SIZE_B:  data_o = {56'd0, shifted[7:0]};
      SIZE_H:  data_o = {48'd0, shifted[15:0]};
      SIZE_W:  data_o = {32'd0, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/if_axi_read_bridge.sv
// Instruction-fetch to AXI4 read bridge. Each fetch request becomes one single-beat
// AXI read (AR then R); the beat is registered and returned with a one-cycle if_ready.
// One transaction in flight at a time; all outputs come from flops.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    if_axi_read_bridge_if.slave: fetch request/response plus AXI AR/R channels
// Parameters:
//   ID_W   width of the AXI id fields
//   AXI_ID id driven on AR; R beats carrying any other id are accepted and dropped
// Build option: define IF_RDATA_ALIGN_EN to return lane-aligned, size-masked data
// instead of the raw 64-bit beat.
module if_axi_read_bridge
  import if_axi_read_bridge_pkg::*;
#(
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  if_axi_read_bridge_if.slave bus
);

  state_e      state_q, state_d;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] data_q;
  logic [1:0]  resp_q;
  logic [63:0] beat_data;
  logic        r_hit;
  logic        ar_valid, r_ready, if_ready;

  // Single-beat reads: last is implied, so the flag is deliberately not used.
  logic unused_r_last;
  assign unused_r_last = bus.axi_r_last;

  assign r_hit = bus.axi_r_valid && (bus.axi_r_id == AXI_ID);

`ifdef IF_RDATA_ALIGN_EN
  if_axi_read_bridge_align u_align (
    .rdata_i  (bus.axi_r_data),
    .offset_i (addr_q[2:0]),
    .size_i   (size_q),
    .data_o   (beat_data)
  );
`else
  assign beat_data = bus.axi_r_data;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.if_valid)     state_d = StAr;
      StAr:   if (bus.axi_ar_ready) state_d = StR;
      StR:    if (r_hit)            state_d = StResp;
      StResp:                       state_d = StIdle;
      default:                      state_d = StIdle;
    endcase
  end

  // Outputs decode only the state register, so no input reaches an output combinationally.
  always_comb begin
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    if_ready = 1'b0;
    unique case (state_q)
      StAr:    ar_valid = 1'b1;
      StR:     r_ready  = 1'b1;
      StResp:  if_ready = 1'b1;
      default: ;
    endcase
  end

  // Request capture and beat capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      size_q <= SIZE_B;
      data_q <= '0;
      resp_q <= AXI_RESP_OKAY;
    end else begin
      if (state_q == StIdle && bus.if_valid) begin
        addr_q <= bus.if_addr;
        size_q <= bus.if_size;
      end
      if (state_q == StR && r_hit) begin
        data_q <= beat_data;
        resp_q <= bus.axi_r_resp;
      end
    end
  end

  assign bus.axi_ar_valid = ar_valid;
  assign bus.axi_ar_addr  = addr_q;
  assign bus.axi_ar_id    = AXI_ID;
  assign bus.axi_ar_len   = 8'd0;
  assign bus.axi_ar_size  = {1'b0, size_q};
  assign bus.axi_ar_burst = AXI_BURST_INCR;
  assign bus.axi_r_ready  = r_ready;
  assign bus.if_ready     = if_ready;
  assign bus.if_data_read = data_q;
  assign bus.if_resp      = resp_q;

endmodule

// File: tb/tb_if_axi_read_bridge.sv
// Self-checking bench for if_axi_read_bridge: directed scenarios then randomized fetches,
// checked against a transaction-level model of the fetch/AXI behaviour.
module tb_if_axi_read_bridge;

  localparam int unsigned   ID_W   = 4;
  localparam logic [3:0]    AXI_ID = 4'd3;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   last_ready_cyc;

  if_axi_read_bridge_if #(.ID_W(ID_W)) bus ();

  if_axi_read_bridge #(
    .ID_W   (ID_W),
    .AXI_ID (AXI_ID)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef IF_RDATA_ALIGN_EN
  // Addressed bytes moved to bit 0, bytes beyond the transfer size cleared.
  function automatic logic [63:0] align_model(logic [63:0] beat, logic [2:0] off,
                                              logic [1:0] size);
    int          nbytes;
    logic [63:0] v;
    nbytes = 1 << size;
    v      = beat >> (8 * int'(off));
    if (nbytes < 8) v = v & ((64'd1 << (8 * nbytes)) - 64'd1);
    return v;
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch, starting in a cycle where the bridge is idle. The AXI slave stalls AR for
  // 'stall' cycles and sends 'bad' wrong-id beats before the real one. Returns in the idle
  // cycle following the if_ready pulse.
  task automatic fetch(input logic [63:0] addr, input logic [1:0] size, input int stall,
                       input int bad, input logic [63:0] beat, input logic [1:0] rresp,
                       input bit drop);
    int          stall_left;
    int          bad_left;
    bit          done;
    logic [63:0] exp_d;
    stall_left = stall;
    bad_left   = bad;
    done       = 1'b0;
`ifdef IF_RDATA_ALIGN_EN
    exp_d = align_model(beat, addr[2:0], size);
`else
    exp_d = beat;
`endif
    bus.if_valid = 1'b1;
    bus.if_addr  = addr;
    bus.if_size  = size;
    for (int n = 0; n < stall + bad + 12 && !done; n++) begin
      if (bus.if_ready) begin
        chk("latency", 64'(n), 64'(3 + stall + bad));
        chk("if_data_read", bus.if_data_read, exp_d);
        chk("if_resp", 64'(bus.if_resp), 64'(rresp));
        last_ready_cyc = cyc;
        done           = 1'b1;
        bus.if_valid   = 1'b0;
        bus.axi_r_valid = 1'b0;
      end else begin
        if (n > 0 && drop) begin
          bus.if_valid = 1'b0;
          bus.if_addr  = {$urandom, $urandom};
          bus.if_size  = 2'($urandom);
        end
        if (bus.axi_ar_valid) begin
          chk("ar_addr", bus.axi_ar_addr, addr);
          if (stall_left > 0) begin
            bus.axi_ar_ready = 1'b0;
            stall_left--;
          end else begin
            bus.axi_ar_ready = 1'b1;
            chk("ar_size", 64'(bus.axi_ar_size), 64'({1'b0, size}));
            chk("ar_len_burst_id",
                64'({bus.axi_ar_len, bus.axi_ar_burst, bus.axi_ar_id}),
                64'({8'd0, 2'b01, AXI_ID}));
          end
        end else begin
          bus.axi_ar_ready = (stall_left == 0);
        end
        bus.axi_r_valid = 1'b1;
        bus.axi_r_last  = 1'($urandom);
        if (bad_left > 0) begin
          bus.axi_r_id   = AXI_ID + 4'd1;
          bus.axi_r_data = ~beat;
          bus.axi_r_resp = 2'($urandom);
          if (bus.axi_r_ready) bad_left--;
        end else begin
          bus.axi_r_id   = AXI_ID;
          bus.axi_r_data = beat;
          bus.axi_r_resp = rresp;
        end
      end
      step();
    end
    if (!done) chk("timeout_if_ready", 64'(done), 64'd1);
    chk("if_ready_one_cycle", 64'(bus.if_ready), 64'd0);
    chk("data_hold", bus.if_data_read, exp_d);
  endtask

  task automatic idle_check(input string tag);
    chk(tag, 64'({bus.axi_ar_valid, bus.axi_r_ready, bus.if_ready}), 64'd0);
  endtask

  initial begin
    int          prev;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp5;
    bit          reached_r;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.if_valid     = 1'b0;
    bus.if_addr      = '0;
    bus.if_size      = 2'b00;
    bus.axi_ar_ready = 1'b0;
    bus.axi_r_valid  = 1'b0;
    bus.axi_r_data   = '0;
    bus.axi_r_resp   = 2'b00;
    bus.axi_r_id     = '0;
    bus.axi_r_last   = 1'b0;

    // Reset values
    step();
    step();
    idle_check("reset_handshakes");
    chk("reset_data", bus.if_data_read, 64'd0);
    chk("reset_resp", 64'(bus.if_resp), 64'd0);
    chk("reset_ar_addr", bus.axi_ar_addr, 64'd0);
    rst_n = 1'b1;
    step();
    step();
    idle_check("idle_no_request");

    // Basic word fetch, zero-wait slave
    fetch(64'h8000_0000, 2'b10, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 1'b0);

    // AR stalled five cycles, request dropped and address scrambled meanwhile
    fetch(64'h8000_0040, 2'b10, 5, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);
    step();
    idle_check("single_pulse_after_stall");

    // Wrong-id beat first, then the real beat with SLVERR
    fetch(64'h8000_0100, 2'b11, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 1'b0);
    chk("slverr_forwarded", 64'(bus.if_resp), 64'd2);

    // Misaligned word fetch: aligned result or raw beat depending on build
    fetch(64'h8000_0004, 2'b10, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b0);
`ifdef IF_RDATA_ALIGN_EN
    exp5 = 64'h0000_0000_AAAA_BBBB;
`else
    exp5 = 64'hAAAA_BBBB_CCCC_DDDD;
`endif
    chk("lane_select", bus.if_data_read, exp5);

    // Reset asserted while waiting in R: outputs drop at once
    bus.if_valid     = 1'b1;
    bus.if_addr      = 64'h9000_0000;
    bus.if_size      = 2'b11;
    bus.axi_ar_ready = 1'b1;
    bus.axi_r_valid  = 1'b0;
    reached_r        = 1'b0;
    for (int n = 0; n < 6 && !reached_r; n++) begin
      step();
      bus.if_valid = 1'b0;
      reached_r    = bus.axi_r_ready;
    end
    chk("reach_r_state", 64'(reached_r), 64'd1);
    rst_n = 1'b0;
    #1;
    idle_check("async_reset_outputs");
    chk("async_reset_data", bus.if_data_read, 64'd0);
    chk("async_reset_ar_addr", bus.axi_ar_addr, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    idle_check("idle_after_reset");
    fetch(64'h8000_0200, 2'b01, 0, 0, 64'h5555_6666_7777_8888, 2'b00, 1'b0);

    // Back-to-back fetches with continuous valid
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = 64'h8000_1000 + 64'(8 * i);
      d = {$urandom, $urandom};
      fetch(a, 2'b11, 0, 0, d, 2'b00, 1'b0);
      if (prev >= 0) chk("b2b_spacing", 64'(last_ready_cyc - prev), 64'd4);
      prev = last_ready_cyc;
    end

    // Randomized fetches
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        idle_check("idle_gap");
      end
      fetch({$urandom, $urandom}, 2'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), {$urandom, $urandom}, 2'($urandom),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
